model_banked_sram: RTL and testbench

- Parametrised behavioural model of a banked single-port memory for simulation and FPGA builds.
- Replaces fixed-geometry stub memory models with NB_BANKS independent banks that actually store data.
- Each bank has a per-bank chip select, write enable, active-low byte enables, address, write data and registered read data.
- A reset-time clear engine zeroes all contents before accesses are accepted. Sits behind the L2/TCDM interconnect in place of hard SRAM/SCM macros.

---
 rtl/model_banked_sram_if.sv | 25 ++
 rtl/model_banked_sram.sv | 98 +++++++++
 tb/tb_model_banked_sram.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/model_banked_sram_if.sv
// rtl/model_banked_sram_if.sv - per-bank request/response bundle for the banked SRAM model
interface model_banked_sram_if #(
  parameter int NB_BANKS   = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  logic [NB_BANKS-1:0]              CEN;
  logic [NB_BANKS-1:0]              WEN;
  logic [NB_BANKS*DATA_WIDTH/8-1:0] BEN;
  logic [NB_BANKS*ADDR_WIDTH-1:0]   A;
  logic [NB_BANKS*DATA_WIDTH-1:0]   D;
  logic [NB_BANKS*DATA_WIDTH-1:0]   Q;
  logic [NB_BANKS-1:0]              oob_err;
  logic                             init_done;

  modport master (
    output CEN, WEN, BEN, A, D,
    input  Q, oob_err, init_done
  );

  modport slave (
    input  CEN, WEN, BEN, A, D,
    output Q, oob_err, init_done
  );
endinterface

// File: rtl/model_banked_sram.sv
// rtl/model_banked_sram.sv - banked single-port memory model with reset-time clear engine
module model_banked_sram #(
  parameter int NB_BANKS       = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter int DEPTH          = 2048,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               CLK,
  input  logic               RSTN,
  model_banked_sram_if.slave bus
);
  localparam int                    NB_BYTES  = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                              state;
  state_t                              state_next;
  logic [ADDR_WIDTH-1:0]               ptr;
  logic [DATA_WIDTH-1:0]               mem [NB_BANKS][DEPTH];

  logic [NB_BANKS-1:0][ADDR_WIDTH-1:0] a_v;
  logic [NB_BANKS-1:0][DATA_WIDTH-1:0] d_v;
  logic [NB_BANKS-1:0][NB_BYTES-1:0]   ben_v;
  logic [NB_BANKS-1:0][DATA_WIDTH-1:0] q_r;
  logic [NB_BANKS-1:0]                 oob_r;
  logic [NB_BANKS-1:0]                 in_range;

  assign a_v           = bus.A;
  assign d_v           = bus.D;
  assign ben_v         = bus.BEN;
  assign bus.Q         = q_r;
  assign bus.oob_err   = oob_r;
  assign bus.init_done = (state == ST_READY);

  always_comb begin
    in_range = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      in_range[b] = ({1'b0, a_v[b]} < DEPTH_EXT);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // The edge that clears the last word is also the edge that enters READY.
  always_comb begin
    state_next = state;
    if (state == ST_CLEAR) begin
      if (CLEAR_ON_RESET == 0 || ptr == LAST_WORD) begin
        state_next = ST_READY;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      q_r   <= '0;
      oob_r <= '0;
      ptr   <= '0;
    end else if (state == ST_CLEAR) begin
      if (CLEAR_ON_RESET != 0) begin
        for (int b = 0; b < NB_BANKS; b++) begin
          mem[b][ptr] <= '0;
        end
        ptr <= ptr + 1'b1;
      end
    end else begin
      for (int b = 0; b < NB_BANKS; b++) begin
        oob_r[b] <= 1'b0;
        if (!bus.CEN[b]) begin
          if (!in_range[b]) begin
            // Out-of-range writes are dropped; out-of-range reads return zero.
            oob_r[b] <= 1'b1;
            if (bus.WEN[b]) begin
              q_r[b] <= '0;
            end
          end else if (bus.WEN[b]) begin
            q_r[b] <= mem[b][a_v[b]];
          end else begin
            for (int i = 0; i < NB_BYTES; i++) begin
              if (!ben_v[b][i]) begin
                mem[b][a_v[b]][8*i +: 8] <= d_v[b][8*i +: 8];
              end
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_model_banked_sram.sv
// tb/tb_model_banked_sram.sv - self-checking bench for model_banked_sram against an array model
module tb_model_banked_sram;
  logic clk = 1'b0;
  logic rstn_a;
  logic rstn_b;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  model_banked_sram_if #(.NB_BANKS(3), .DATA_WIDTH(32), .ADDR_WIDTH(11)) bus_a ();
  model_banked_sram_if #(.NB_BANKS(3), .DATA_WIDTH(32), .ADDR_WIDTH(11)) bus_b ();

  model_banked_sram #(.NB_BANKS(3), .DATA_WIDTH(32), .ADDR_WIDTH(11), .DEPTH(2048), .CLEAR_ON_RESET(1))
    dut_a (.CLK(clk), .RSTN(rstn_a), .bus(bus_a));
  model_banked_sram #(.NB_BANKS(3), .DATA_WIDTH(32), .ADDR_WIDTH(11), .DEPTH(1536), .CLEAR_ON_RESET(1))
    dut_b (.CLK(clk), .RSTN(rstn_b), .bus(bus_b));

  // Reference: index 0 is the 2048-word instance, index 1 the 1536-word instance.
  logic [31:0] mem_ref [2][3][2048];
  logic [31:0] exp_q   [2][3];
  logic        exp_oob [3];

  logic [2:0]  s_cen;
  logic [2:0]  s_wen;
  logic [3:0]  s_ben  [3];
  int          s_addr [3];
  logic [31:0] s_d    [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    s_cen = 3'b111;
    s_wen = 3'b111;
    for (int b = 0; b < 3; b++) begin
      s_ben[b]  = 4'hf;
      s_addr[b] = 0;
      s_d[b]    = '0;
    end
    bus_a.CEN = 3'b111; bus_a.WEN = 3'b111; bus_a.BEN = '1; bus_a.A = '0; bus_a.D = '0;
    bus_b.CEN = 3'b111; bus_b.WEN = 3'b111; bus_b.BEN = '1; bus_b.A = '0; bus_b.D = '0;
  endtask

  task automatic set_bank(input int b, input logic cen, input logic wen, input logic [3:0] ben,
                          input int addr, input logic [31:0] d);
    s_cen[b]  = cen;
    s_wen[b]  = wen;
    s_ben[b]  = ben;
    s_addr[b] = addr;
    s_d[b]    = d;
  endtask

  // One clocked access cycle on instance u; all banks of that instance are checked after the edge.
  task automatic step(input int u);
    int depth;
    logic [95:0] q_obs;
    logic [2:0]  oob_obs;
    depth = (u == 1) ? 1536 : 2048;
    for (int b = 0; b < 3; b++) begin
      exp_oob[b] = 1'b0;
      if (!s_cen[b]) begin
        if (s_addr[b] >= depth) begin
          exp_oob[b] = 1'b1;
          if (s_wen[b]) exp_q[u][b] = '0;
        end else if (s_wen[b]) begin
          exp_q[u][b] = mem_ref[u][b][s_addr[b]];
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (!s_ben[b][i]) mem_ref[u][b][s_addr[b]][8*i +: 8] = s_d[b][8*i +: 8];
          end
        end
      end
    end
    for (int b = 0; b < 3; b++) begin
      if (u == 0) begin
        bus_a.A[b*11 +: 11] = s_addr[b][10:0]; bus_a.D[b*32 +: 32] = s_d[b];
        bus_a.BEN[b*4 +: 4] = s_ben[b];
      end else begin
        bus_b.A[b*11 +: 11] = s_addr[b][10:0]; bus_b.D[b*32 +: 32] = s_d[b];
        bus_b.BEN[b*4 +: 4] = s_ben[b];
      end
    end
    if (u == 0) begin bus_a.CEN = s_cen; bus_a.WEN = s_wen; end
    else        begin bus_b.CEN = s_cen; bus_b.WEN = s_wen; end
    tick();
    q_obs   = (u == 0) ? bus_a.Q : bus_b.Q;
    oob_obs = (u == 0) ? bus_a.oob_err : bus_b.oob_err;
    for (int b = 0; b < 3; b++) begin
      check($sformatf("q u%0d b%0d", u, b), q_obs[b*32 +: 32], exp_q[u][b]);
      check($sformatf("oob u%0d b%0d", u, b), {31'd0, oob_obs[b]}, {31'd0, exp_oob[b]});
    end
    idle_all();
  endtask

  initial begin
    int n;
    int na;
    int nb;
    for (int u = 0; u < 2; u++)
      for (int b = 0; b < 3; b++) begin
        exp_q[u][b] = '0;
        for (int w = 0; w < 2048; w++) mem_ref[u][b][w] = '0;
      end
    idle_all();
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    tick();
    tick();
    for (int b = 0; b < 3; b++) check($sformatf("rst q b%0d", b), bus_a.Q[b*32 +: 32], 32'h0);
    check("rst oob", {29'd0, bus_a.oob_err}, 32'h0);
    check("rst init_done", {31'd0, bus_a.init_done}, 32'h0);

    // Clear from release; a write issued during the clear must be ignored.
    rstn_a = 1'b1;
    rstn_b = 1'b1;
    bus_a.CEN = 3'b110; bus_a.WEN = 3'b110; bus_a.BEN = '0; bus_a.A = '0;
    bus_a.D = {3{32'h12345678}};
    n = 0; na = 0; nb = 0;
    while (n < 5000 && (na == 0 || nb == 0)) begin
      tick();
      n++;
      if (n == 1) begin
        check("clear oob", {29'd0, bus_a.oob_err}, 32'h0);
        check("clear q0", bus_a.Q[31:0], 32'h0);
        idle_all();
      end
      if (na == 0 && bus_a.init_done) na = n;
      if (nb == 0 && bus_b.init_done) nb = n;
    end
    check("init edges a", na, 2048);
    check("init edges b", nb, 1536);

    // Reset asserted in the middle of the clear restarts it from word 0.
    rstn_a = 1'b0;
    tick(); tick();
    rstn_a = 1'b1;
    repeat (1000) tick();
    check("midclear init low", {31'd0, bus_a.init_done}, 32'h0);
    rstn_a = 1'b0;
    tick();
    rstn_a = 1'b1;
    check("midclear q", bus_a.Q[31:0] | bus_a.Q[63:32] | bus_a.Q[95:64], 32'h0);
    n = 0;
    while (n < 5000 && !bus_a.init_done) begin
      tick();
      n++;
    end
    check("reinit edges", n, 2048);

    // Cleared contents across the array, including the word written during clear.
    foreach (s_addr[k]) ;
    for (int k = 0; k < 3; k++) begin
      int addr;
      addr = (k == 0) ? 0 : (k == 1) ? 1000 : 2047;
      for (int b = 0; b < 3; b++) set_bank(b, 1'b0, 1'b1, 4'hf, addr, 32'h0);
      step(0);
    end

    // Byte-enable merge on bank 1.
    set_bank(1, 1'b0, 1'b0, 4'b0000, 5, 32'hDEADBEEF); step(0);
    set_bank(1, 1'b0, 1'b0, 4'b1010, 5, 32'h11223344); step(0);
    set_bank(1, 1'b0, 1'b1, 4'hf, 5, 32'h0);           step(0);
    check("merge", bus_a.Q[63:32], 32'hDE22BE44);

    // Concurrent banks; bank 2 holds a known non-zero value beforehand.
    set_bank(2, 1'b0, 1'b0, 4'h0, 3, 32'hCAFEF00D); step(0);
    set_bank(2, 1'b0, 1'b1, 4'hf, 3, 32'h0);        step(0);
    set_bank(0, 1'b0, 1'b0, 4'h0, 7, 32'hA5A5A5A5);
    set_bank(1, 1'b0, 1'b1, 4'hf, 7, 32'h0);
    step(0);
    check("concur b1", bus_a.Q[63:32], 32'h0);
    check("concur b2", bus_a.Q[95:64], 32'hCAFEF00D);
    set_bank(0, 1'b0, 1'b1, 4'hf, 7, 32'h0); step(0);
    check("concur b0 rd", bus_a.Q[31:0], 32'hA5A5A5A5);

    // Out-of-range on the 1536-word instance.
    set_bank(0, 1'b0, 1'b1, 4'hf, 10, 32'h0); step(1);
    set_bank(0, 1'b0, 1'b0, 4'h0, 1600, 32'hFFFFFFFF); step(1);
    check("oob wr pulse", {31'd0, bus_b.oob_err[0]}, 32'h1);
    step(1);
    check("oob wr drop", {31'd0, bus_b.oob_err[0]}, 32'h0);
    set_bank(0, 1'b0, 1'b1, 4'hf, 1600, 32'h0); step(1);
    check("oob rd q", bus_b.Q[31:0], 32'h0);
    set_bank(0, 1'b0, 1'b1, 4'hf, 64, 32'h0); step(1);
    check("oob alias", bus_b.Q[31:0], 32'h0);

    // Random traffic against the model on both instances.
    for (int t = 0; t < 400; t++) begin
      int u;
      u = t % 2;
      for (int b = 0; b < 3; b++) begin
        int addr;
        if (u == 1 && $urandom_range(0, 1) == 1) addr = $urandom_range(1528, 1543);
        else addr = $urandom_range(0, 15);
        set_bank(b, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 4'($urandom), addr, $urandom);
      end
      step(u);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
